// File: rtl/lock_sequencer.sv
// -----------------------------------------------------------------------------
// lock_sequencer
//
// Central control FSM for the keypad lock. Decoded keypad digits are routed
// into either the setpoint (SP) shift bank or the user-input (UI) bank using
// explicit one-cycle shift enables. A full entry triggers a compare, failed
// attempts are counted, and the unlocked / alarm outputs are driven. The
// banks, the comparator and this sequencer all run on the one clock.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active-low
//   mode_sel     01 = program SP, 00 = user entry, 1x = idle
//   key_valid    one-cycle pulse per keypress
//   key_code     BCD digit; codes above 9 are dropped
//   match        comparator result (UI bank == SP bank)
//   alarm_clr    level request to clear the alarm
//   shift_data   digit presented to the shift banks
//   ui_shift_en  one-cycle shift pulse, UI bank
//   sp_shift_en  one-cycle shift pulse, SP bank
//   ui_clr       one-cycle clear pulse, UI bank
//   sp_clr       one-cycle clear pulse, SP bank
//   digit_cnt    digits accepted in the current entry
//   attempts     failed-attempt count
//   pass_set     a complete passcode is stored
//   unlocked     lock open
//   alarm        alarm active
// -----------------------------------------------------------------------------
module lock_sequencer #(
    parameter int NUM_DIGITS     = 8,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int UNLOCK_CYCLES  = 16,
    parameter int LOCKOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode_sel,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       match,
    input  logic       alarm_clr,
    output logic [3:0] shift_data,
    output logic       ui_shift_en,
    output logic       sp_shift_en,
    output logic       ui_clr,
    output logic       sp_clr,
    output logic [3:0] digit_cnt,
    output logic [3:0] attempts,
    output logic       pass_set,
    output logic       unlocked,
    output logic       alarm
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PROG     = 3'd1;
    localparam logic [2:0] ST_ENTRY    = 3'd2;
    localparam logic [2:0] ST_CHECK    = 3'd3;
    localparam logic [2:0] ST_UNLOCKED = 3'd4;
    localparam logic [2:0] ST_ALARM    = 3'd5;

    localparam int UNLOCK_W  = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;
    localparam int LOCKOUT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    localparam logic [3:0]           DIGITS_LAST  = 4'(NUM_DIGITS - 1);
    localparam logic [3:0]           ATTEMPTS_MAX = 4'(MAX_ATTEMPTS);
    localparam logic [UNLOCK_W-1:0]  UNLOCK_LAST  = UNLOCK_W'(UNLOCK_CYCLES - 1);
    localparam logic [LOCKOUT_W-1:0] LOCKOUT_LAST = LOCKOUT_W'(LOCKOUT_CYCLES - 1);

    logic [2:0]           state;
    logic [2:0]           state_nxt;
    logic                 check_phase;
    logic                 check_phase_nxt;
    logic [UNLOCK_W-1:0]  unlock_cnt;
    logic [UNLOCK_W-1:0]  unlock_cnt_nxt;
    logic [LOCKOUT_W-1:0] lockout_cnt;
    logic [LOCKOUT_W-1:0] lockout_cnt_nxt;

    logic [3:0] shift_data_nxt;
    logic       ui_shift_en_nxt;
    logic       sp_shift_en_nxt;
    logic       ui_clr_nxt;
    logic       sp_clr_nxt;
    logic [3:0] digit_cnt_nxt;
    logic [3:0] attempts_nxt;
    logic       pass_set_nxt;
    logic       unlocked_nxt;
    logic       alarm_nxt;

    logic       key_ok;
    logic       mode_prog;
    logic       mode_user;
    logic       last_digit;
    logic [3:0] attempts_inc;

    assign key_ok       = key_valid && (key_code <= 4'd9);
    assign mode_prog    = (mode_sel == 2'b01);
    assign mode_user    = (mode_sel == 2'b00);
    assign last_digit   = (digit_cnt == DIGITS_LAST);
    assign attempts_inc = attempts + 4'd1;

    always_comb begin
        state_nxt       = state;
        check_phase_nxt = check_phase;
        unlock_cnt_nxt  = unlock_cnt;
        lockout_cnt_nxt = lockout_cnt;
        shift_data_nxt  = shift_data;
        ui_shift_en_nxt = 1'b0;
        sp_shift_en_nxt = 1'b0;
        ui_clr_nxt      = 1'b0;
        sp_clr_nxt      = 1'b0;
        digit_cnt_nxt   = digit_cnt;
        attempts_nxt    = attempts;
        pass_set_nxt    = pass_set;
        unlocked_nxt    = unlocked;
        alarm_nxt       = alarm;

        case (state)
            ST_IDLE: begin
                if (mode_prog) begin
                    // Reprogramming invalidates the stored code until it completes.
                    state_nxt     = ST_PROG;
                    sp_clr_nxt    = 1'b1;
                    pass_set_nxt  = 1'b0;
                    digit_cnt_nxt = 4'd0;
                end else if (mode_user && pass_set) begin
                    state_nxt     = ST_ENTRY;
                    ui_clr_nxt    = 1'b1;
                    digit_cnt_nxt = 4'd0;
                end
            end

            ST_PROG: begin
                // Mode change is checked first so a coincident key is dropped.
                if (!mode_prog) begin
                    state_nxt     = ST_IDLE;
                    pass_set_nxt  = 1'b0;
                    digit_cnt_nxt = 4'd0;
                end else if (key_ok) begin
                    sp_shift_en_nxt = 1'b1;
                    shift_data_nxt  = key_code;
                    if (last_digit) begin
                        state_nxt     = ST_IDLE;
                        pass_set_nxt  = 1'b1;
                        attempts_nxt  = 4'd0;
                        digit_cnt_nxt = 4'd0;
                    end else begin
                        digit_cnt_nxt = digit_cnt + 4'd1;
                    end
                end
            end

            ST_ENTRY: begin
                // An aborted entry keeps its digit count and attempt count.
                if (!mode_user) begin
                    state_nxt  = ST_IDLE;
                    ui_clr_nxt = 1'b1;
                end else if (key_ok) begin
                    ui_shift_en_nxt = 1'b1;
                    shift_data_nxt  = key_code;
                    if (last_digit) begin
                        state_nxt       = ST_CHECK;
                        digit_cnt_nxt   = 4'd0;
                        check_phase_nxt = 1'b0;
                    end else begin
                        digit_cnt_nxt = digit_cnt + 4'd1;
                    end
                end
            end

            ST_CHECK: begin
                // First cycle lets the final shift land in the UI bank; the
                // comparator is trusted only in the second cycle.
                if (!check_phase) begin
                    check_phase_nxt = 1'b1;
                end else if (match) begin
                    state_nxt      = ST_UNLOCKED;
                    unlocked_nxt   = 1'b1;
                    attempts_nxt   = 4'd0;
                    unlock_cnt_nxt = '0;
                end else if (attempts_inc >= ATTEMPTS_MAX) begin
                    state_nxt       = ST_ALARM;
                    alarm_nxt       = 1'b1;
                    attempts_nxt    = ATTEMPTS_MAX;
                    lockout_cnt_nxt = '0;
                end else begin
                    state_nxt     = ST_ENTRY;
                    attempts_nxt  = attempts_inc;
                    ui_clr_nxt    = 1'b1;
                    digit_cnt_nxt = 4'd0;
                end
            end

            ST_UNLOCKED: begin
                if (unlock_cnt == UNLOCK_LAST) begin
                    state_nxt    = ST_IDLE;
                    unlocked_nxt = 1'b0;
                    ui_clr_nxt   = 1'b1;
                end else begin
                    unlock_cnt_nxt = unlock_cnt + UNLOCK_W'(1);
                end
            end

            ST_ALARM: begin
                // Early clear requests are ignored; the counter saturates so a
                // request held past expiry is still honoured.
                if (alarm_clr && (lockout_cnt >= LOCKOUT_LAST)) begin
                    state_nxt    = ST_IDLE;
                    alarm_nxt    = 1'b0;
                    attempts_nxt = 4'd0;
                    ui_clr_nxt   = 1'b1;
                end else if (lockout_cnt != LOCKOUT_LAST) begin
                    lockout_cnt_nxt = lockout_cnt + LOCKOUT_W'(1);
                end
            end

            default: begin
                state_nxt    = ST_IDLE;
                unlocked_nxt = 1'b0;
                alarm_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            check_phase <= 1'b0;
            unlock_cnt  <= '0;
            lockout_cnt <= '0;
            shift_data  <= 4'd0;
            ui_shift_en <= 1'b0;
            sp_shift_en <= 1'b0;
            ui_clr      <= 1'b0;
            sp_clr      <= 1'b0;
            digit_cnt   <= 4'd0;
            attempts    <= 4'd0;
            pass_set    <= 1'b0;
            unlocked    <= 1'b0;
            alarm       <= 1'b0;
        end else begin
            state       <= state_nxt;
            check_phase <= check_phase_nxt;
            unlock_cnt  <= unlock_cnt_nxt;
            lockout_cnt <= lockout_cnt_nxt;
            shift_data  <= shift_data_nxt;
            ui_shift_en <= ui_shift_en_nxt;
            sp_shift_en <= sp_shift_en_nxt;
            ui_clr      <= ui_clr_nxt;
            sp_clr      <= sp_clr_nxt;
            digit_cnt   <= digit_cnt_nxt;
            attempts    <= attempts_nxt;
            pass_set    <= pass_set_nxt;
            unlocked    <= unlocked_nxt;
            alarm       <= alarm_nxt;
        end
    end

endmodule
